// File: rtl/fma_issue_ctrl.sv
// Issue controller for an externally pipelined FMA unit: credit-based operand issue,
// a valid/tag shadow pipeline, and a first-word-fall-through result FIFO.
module fma_issue_ctrl #(
  parameter int LATENCY = 5,
  parameter int DEPTH   = 8,
  parameter int TAGW    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_a,
  input  logic [31:0]                  in_b,
  input  logic [31:0]                  in_c,
  input  logic [TAGW-1:0]              in_tag,
  output logic [31:0]                  fma_a,
  output logic [31:0]                  fma_b,
  output logic [31:0]                  fma_c,
  input  logic [31:0]                  fma_result,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_result,
  output logic [TAGW-1:0]              out_tag,
  output logic [$clog2(LATENCY+1)-1:0] inflight,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow_err
);

  localparam int IW = $clog2(LATENCY+1);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = ((IW > CW) ? IW : CW) + 1;

  logic [LATENCY-1:0] vld;
  logic [TAGW-1:0]    tag_sr     [LATENCY];
  logic [31:0]        mem_result [DEPTH];
  logic [TAGW-1:0]    mem_tag    [DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [SW-1:0]      occupied;
  logic               fire;
  logic               capture;
  logic               pop;
  logic               push;
  logic               full;

  // Every op in flight already owns a FIFO slot, so the FIFO can never overflow.
  assign occupied = SW'(fifo_count) + SW'(inflight);
  assign in_ready = !rst && (occupied < SW'(DEPTH));
  assign fire     = in_valid && in_ready;

  assign fma_a = fire ? in_a : 32'h0;
  assign fma_b = fire ? in_b : 32'h0;
  assign fma_c = fire ? in_c : 32'h0;

  assign capture    = vld[LATENCY-1];
  assign out_valid  = (fifo_count != '0);
  assign pop        = out_valid && out_ready;
  assign full       = (fifo_count == CW'(DEPTH));
  assign push       = capture && (!full || pop);
  assign out_result = mem_result[rd_ptr];
  assign out_tag    = mem_tag[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld          <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      inflight     <= '0;
      fifo_count   <= '0;
      overflow_err <= 1'b0;
    end else begin
      vld[0] <= fire;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
      end

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      if (fire && !capture) begin
        inflight <= inflight + IW'(1);
      end else if (!fire && capture) begin
        inflight <= inflight - IW'(1);
      end

      if (push && !pop) begin
        fifo_count <= fifo_count + CW'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CW'(1);
      end

      if (capture && full && !pop) overflow_err <= 1'b1;
    end
  end

  // Datapath storage needs no reset: validity is tracked entirely by vld and the pointers.
  always_ff @(posedge clk) begin
    tag_sr[0] <= in_tag;
    for (int i = 1; i < LATENCY; i++) begin
      tag_sr[i] <= tag_sr[i-1];
    end
    if (push) begin
      mem_result[wr_ptr] <= fma_result;
      mem_tag[wr_ptr]    <= tag_sr[LATENCY-1];
    end
  end

endmodule

// File: tb/tb_fma_issue_ctrl.sv
// Bench for fma_issue_ctrl: a fixed-latency FMA model on integer-valued floats,
// a queue scoreboard in issue order, and directed plus randomized phases.
module tb_fma_issue_ctrl;

  localparam int LATENCY = 5;
  localparam int DEPTH   = 8;
  localparam int TAGW    = 4;
  localparam int IW      = $clog2(LATENCY+1);
  localparam int CW      = $clog2(DEPTH+1);

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_a;
  logic [31:0]       in_b;
  logic [31:0]       in_c;
  logic [TAGW-1:0]   in_tag;
  logic [31:0]       fma_a;
  logic [31:0]       fma_b;
  logic [31:0]       fma_c;
  logic [31:0]       fma_result;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic [TAGW-1:0]   out_tag;
  logic [IW-1:0]     inflight;
  logic [CW-1:0]     fifo_count;
  logic              overflow_err;

  logic [31:0]       fpipe [LATENCY];
  logic              rst_fill;
  logic [TAGW+31:0]  sb [$];

  int compared   = 0;
  int mismatched = 0;
  int fires      = 0;
  int pops       = 0;
  int first_pop  = -1;
  int last_pop   = -1;
  int cyc        = 0;

  fma_issue_ctrl #(.LATENCY(LATENCY), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_tag(in_tag),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_result(fma_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .inflight(inflight), .fifo_count(fifo_count), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned fp_to_int(input logic [31:0] f);
    int p;
    logic [31:0] m;
    if (f[30:23] == 8'd0) return 0;
    p = int'(f[30:23]) - 127;
    m = {8'd0, 1'b1, f[22:0]};
    return m >> (23 - p);
  endfunction

  function automatic logic [31:0] int_to_fp(input int unsigned n);
    int p;
    logic [31:0] mant;
    if (n == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 32; i++) if (n[i]) p = i;
    mant = n << (23 - p);
    return {1'b0, 8'(127 + p), mant[22:0]};
  endfunction

  function automatic logic [31:0] fma_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
    return int_to_fp(fp_to_int(a) * fp_to_int(b) + fp_to_int(c));
  endfunction

  // External FMA: unreset pipeline, seeded with garbage before first use.
  always @(posedge clk) begin
    if (rst_fill) begin
      for (int i = 0; i < LATENCY; i++) fpipe[i] <= 32'hBAD0_0000 + 32'(i);
    end else begin
      fpipe[0] <= fma_fn(fma_a, fma_b, fma_c);
      for (int i = 1; i < LATENCY; i++) fpipe[i] <= fpipe[i-1];
    end
  end
  assign fma_result = fpipe[LATENCY-1];

  task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_random_op();
    in_a   = int_to_fp($urandom_range(1000));
    in_b   = int_to_fp($urandom_range(1000));
    in_c   = int_to_fp($urandom_range(1000));
    in_tag = TAGW'($urandom_range(15));
  endtask

  // One cycle: record fires into the scoreboard, score pops, advance to next negedge.
  task automatic apply_stimulus();
    logic [TAGW+31:0] exp;
    #1;
    if (in_valid && in_ready) begin
      sb.push_back({in_tag, fma_fn(in_a, in_b, in_c)});
      fires++;
    end
    if (out_valid && out_ready) begin
      pops++;
      last_pop = cyc;
      if (first_pop < 0) first_pop = cyc;
      check_output("sb_nonempty_on_pop", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check_output("out_result", 64'(out_result), 64'(exp[31:0]));
        check_output("out_tag", 64'(out_tag), 64'(exp[TAGW+31:32]));
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    int guard;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    guard     = 0;
    while ((sb.size() != 0 || out_valid) && guard < 200) begin
      apply_stimulus();
      guard++;
    end
    check_output("drain_done", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int base;
    int guard;
    rst       = 1'b1;
    rst_fill  = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    set_random_op();

    $display("[TB] reset");
    @(negedge clk);
    @(negedge clk);
    #1;
    check_output("rst_in_ready", 64'(in_ready), 64'd0);
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_fifo_count", 64'(fifo_count), 64'd0);
    check_output("rst_inflight", 64'(inflight), 64'd0);
    check_output("rst_overflow", 64'(overflow_err), 64'd0);
    check_output("rst_fma_a", 64'(fma_a), 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    rst_fill = 1'b0;
    in_valid = 1'b0;
    #1;
    check_output("in_ready_after_rst", 64'(in_ready), 64'd1);

    $display("[TB] single op latency");
    in_valid = 1'b1;
    in_a = 32'h3F80_0000; in_b = 32'h4000_0000; in_c = 32'h3F80_0000; in_tag = 4'd5;
    #1;
    check_output("fire_fma_a", 64'(fma_a), 64'h3F80_0000);
    check_output("fire_fma_b", 64'(fma_b), 64'h4000_0000);
    check_output("fire_fma_c", 64'(fma_c), 64'h3F80_0000);
    apply_stimulus();
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      check_output($sformatf("out_valid_at_T+%0d", k), 64'(out_valid), 64'(k == 6));
      if (k < 6) apply_stimulus();
    end
    check_output("single_result", 64'(out_result), 64'h4040_0000);
    check_output("single_tag", 64'(out_tag), 64'd5);
    check_output("idle_fma_a", 64'(fma_a), 64'd0);
    out_ready = 1'b1;
    apply_stimulus();
    out_ready = 1'b0;

    $display("[TB] back-to-back");
    first_pop = -1;
    base      = pops;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      set_random_op();
      in_tag = TAGW'(i % 16);
      check_output("b2b_in_ready", 64'(in_ready), 64'd1);
      apply_stimulus();
    end
    drain();
    check_output("b2b_pops", 64'(pops - base), 64'd20);
    check_output("b2b_no_gaps", 64'(last_pop - first_pop), 64'd19);

    $display("[TB] fill with out_ready low");
    out_ready = 1'b0;
    base      = fires;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      set_random_op();
      apply_stimulus();
    end
    check_output("fill_fires", 64'(fires - base), 64'(DEPTH));
    check_output("fill_in_ready", 64'(in_ready), 64'd0);
    check_output("fill_fifo_count", 64'(fifo_count), 64'(DEPTH));
    check_output("fill_inflight", 64'(inflight), 64'd0);
    check_output("fill_overflow", 64'(overflow_err), 64'd0);

    $display("[TB] single pop from full");
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_output("pop_cycle_in_ready", 64'(in_ready), 64'd0);
    apply_stimulus();
    out_ready = 1'b0;
    check_output("after_pop_in_ready", 64'(in_ready), 64'd1);
    base     = fires;
    in_valid = 1'b1;
    set_random_op();
    apply_stimulus();
    in_valid = 1'b0;
    check_output("refill_fire", 64'(fires - base), 64'd1);
    check_output("refill_in_ready", 64'(in_ready), 64'd0);
    drain();

    $display("[TB] reset mid-operation");
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      set_random_op();
      apply_stimulus();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) apply_stimulus();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      set_random_op();
      apply_stimulus();
    end
    in_valid = 1'b0;
    check_output("pre_rst_inflight", 64'(inflight), 64'd3);
    check_output("pre_rst_fifo_count", 64'(fifo_count), 64'd2);
    rst = 1'b1;
    #1;
    check_output("mid_rst_inflight", 64'(inflight), 64'd0);
    check_output("mid_rst_fifo_count", 64'(fifo_count), 64'd0);
    check_output("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_output("mid_rst_in_ready", 64'(in_ready), 64'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_output("post_rst_no_stale", 64'(out_valid), 64'd0);
      apply_stimulus();
    end

    $display("[TB] random traffic");
    base  = fires;
    guard = 0;
    while ((fires - base) < 10000 && guard < 40000) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      set_random_op();
      #1;
      check_output("credit_invariant", 64'((int'(fifo_count) + int'(inflight)) <= DEPTH), 64'd1);
      if (!in_valid) check_output("idle_fma_b", 64'(fma_b), 64'd0);
      apply_stimulus();
      guard++;
    end
    check_output("random_fires", 64'(fires - base >= 10000), 64'd1);
    drain();
    check_output("final_overflow", 64'(overflow_err), 64'd0);
    check_output("final_fifo_count", 64'(fifo_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
